// File: rtl/cardinal_nic_arbiter.sv
// Two-requester transmit / single-consumer receive arbiter for a gold_nic.
// Polls NIC status registers before every buffer access; TX/RX alternate by turn.
module cardinal_nic_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [0:1]            nic_addr,
    output logic [0:DATA_WIDTH-1] nic_di,
    output logic                  nic_en,
    output logic                  nic_wren,
    input  logic [0:DATA_WIDTH-1] nic_do,
    input  logic                  req0_valid,
    input  logic [0:DATA_WIDTH-1] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [0:DATA_WIDTH-1] req1_data,
    output logic                  req1_ready,
    output logic                  rx_valid,
    output logic [0:DATA_WIDTH-1] rx_data,
    input  logic                  rx_ready
);

    typedef enum logic [2:0] {
        IDLE,
        TX_POLL,
        TX_WAIT,
        TX_WRITE,
        RX_POLL,
        RX_WAIT,
        RX_READ,
        RX_RDWAIT
    } state_t;

    state_t                  state_q, state_d;
    logic                    rr_q, rr_d;
    logic                    turn_q, turn_d;
    logic                    grant_q, grant_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [0:DATA_WIDTH-1]   rx_data_q, rx_data_d;

    logic status_full;
    logic tx_elig;
    logic rx_elig;

    // Status flag sits in the last bit of the big-endian word.
    assign status_full = nic_do[DATA_WIDTH-1];
    assign tx_elig     = req0_valid | req1_valid;
    assign rx_elig     = ~rx_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            turn_q     <= 1'b0;
            grant_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            turn_q     <= turn_d;
            grant_q    <= grant_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        turn_d     = turn_q;
        grant_d    = grant_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (tx_elig && (!rx_elig || !turn_q)) begin
                    state_d = TX_POLL;
                    turn_d  = 1'b1;
                    grant_d = (req0_valid && req1_valid) ? rr_q : req1_valid;
                end else if (rx_elig) begin
                    state_d = RX_POLL;
                    turn_d  = 1'b0;
                end
            end
            TX_POLL:   state_d = TX_WAIT;
            TX_WAIT:   state_d = status_full ? IDLE : TX_WRITE;
            TX_WRITE: begin
                state_d = IDLE;
                rr_d    = ~grant_q;
            end
            RX_POLL:   state_d = RX_WAIT;
            RX_WAIT:   state_d = status_full ? RX_READ : IDLE;
            RX_READ:   state_d = RX_RDWAIT;
            RX_RDWAIT: begin
                state_d    = IDLE;
                rx_valid_d = 1'b1;
                rx_data_d  = nic_do;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        nic_en     = 1'b0;
        nic_wren   = 1'b0;
        nic_addr   = 2'b00;
        nic_di     = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            TX_POLL: begin
                nic_en   = 1'b1;
                nic_addr = 2'b11;
            end
            TX_WRITE: begin
                nic_en     = 1'b1;
                nic_wren   = 1'b1;
                nic_addr   = 2'b10;
                nic_di     = grant_q ? req1_data : req0_data;
                req0_ready = ~grant_q;
                req1_ready = grant_q;
            end
            RX_POLL: begin
                nic_en   = 1'b1;
                nic_addr = 2'b01;
            end
            RX_READ: begin
                nic_en   = 1'b1;
                nic_addr = 2'b00;
            end
            default: begin
                nic_en = 1'b0;
            end
        endcase
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_cardinal_nic_arbiter.sv
// Directed bench for cardinal_nic_arbiter with a behavioural gold_nic model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_cardinal_nic_arbiter;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:1]    nic_addr;
    logic [0:DW-1] nic_di;
    logic          nic_en;
    logic          nic_wren;
    logic [0:DW-1] nic_do;
    logic          req0_valid;
    logic [0:DW-1] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [0:DW-1] req1_data;
    logic          req1_ready;
    logic          rx_valid;
    logic [0:DW-1] rx_data;
    logic          rx_ready;

    logic          in_full;
    logic          out_full;
    logic [0:DW-1] in_buf;

    int total = 0;
    int bad   = 0;

    logic [0:DW-1] wlog[$];
    int            rlog[$];
    int            txp   = 0;
    int            rxp   = 0;
    int            badwr = 0;
    bit            pend  = 0;
    bit            ok    = 0;

    always #5 clk = ~clk;

    cardinal_nic_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .nic_addr   (nic_addr),
        .nic_di     (nic_di),
        .nic_en     (nic_en),
        .nic_wren   (nic_wren),
        .nic_do     (nic_do),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready)
    );

    // gold_nic: read data appears the cycle after the access
    initial nic_do = '0;
    always @(posedge clk) begin : nic_model
        logic [0:DW-1] t;
        if (nic_en && !nic_wren) begin
            t = '0;
            case (nic_addr)
                2'b00:   t = in_buf;
                2'b01:   t[DW-1] = in_full;
                2'b11:   t[DW-1] = out_full;
                default: t = '0;
            endcase
            nic_do <= t;
        end
    end

    // log writes, ready pulses, polls; flag writes not preceded by not-full
    always @(posedge clk) begin
        if (pend) ok = !nic_do[DW-1];
        if (nic_en && nic_wren) begin
            wlog.push_back(nic_di);
            if (!ok) badwr++;
            ok = 0;
        end
        pend = nic_en && !nic_wren && nic_addr == 2'b11;
        if (nic_en && !nic_wren && nic_addr == 2'b11) txp++;
        if (nic_en && !nic_wren && nic_addr == 2'b01) rxp++;
        if (req0_ready) rlog.push_back(0);
        if (req1_ready) rlog.push_back(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int wb, rb, tb0, xb;

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        rx_ready   = 1'b0;
        in_full    = 1'b0;
        out_full   = 1'b0;
        in_buf     = '0;
        repeat (3) tick;

        chk("rst_en",   64'(nic_en), 64'd0);
        chk("rst_wren", 64'(nic_wren), 64'd0);
        chk("rst_addr", 64'(nic_addr), 64'd0);
        chk("rst_di",   64'(nic_di), 64'd0);
        chk("rst_rxv",  64'(rx_valid), 64'd0);
        chk("rst_rxd",  64'(rx_data), 64'd0);
        chk("rst_rdy",  64'({req0_ready, req1_ready}), 64'd0);

        // single requester, best-case latency
        req0_data  = 64'hA5;
        req0_valid = 1'b1;
        reset      = 1'b0;
        tick;
        chk("t1_poll_en",   64'(nic_en), 64'd1);
        chk("t1_poll_addr", 64'(nic_addr), 64'd3);
        chk("t1_poll_wren", 64'(nic_wren), 64'd0);
        tick;
        chk("t1_wait_en", 64'(nic_en), 64'd0);
        tick;
        chk("t1_wr_en",   64'(nic_en), 64'd1);
        chk("t1_wr_wren", 64'(nic_wren), 64'd1);
        chk("t1_wr_addr", 64'(nic_addr), 64'd2);
        chk("t1_wr_di",   64'(nic_di), 64'hA5);
        chk("t1_rdy0",    64'(req0_ready), 64'd1);
        chk("t1_rdy1",    64'(req1_ready), 64'd0);
        req0_valid = 1'b0;
        tick;
        chk("t1_idle_rdy0", 64'(req0_ready), 64'd0);
        chk("t1_idle_en",   64'(nic_en), 64'd0);
        tick;
        chk("t1_rx_en",   64'(nic_en), 64'd1);
        chk("t1_rx_addr", 64'(nic_addr), 64'd1);

        // both requesters, round robin
        reset = 1'b1;
        repeat (2) tick;
        req0_data  = 64'h1;
        req1_data  = 64'h2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset      = 1'b0;
        wb = wlog.size();
        rb = rlog.size();
        for (int i = 0; i < 200; i++) begin
            tick;
            if (rlog.size() >= rb + 4) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t2_nrdy", 64'(rlog.size() - rb), 64'd4);
        chk("t2_nwr",  64'(wlog.size() - wb), 64'd4);
        if (wlog.size() >= wb + 4 && rlog.size() >= rb + 4) begin
            chk("t2_wr0", 64'(wlog[wb]),     64'h1);
            chk("t2_wr1", 64'(wlog[wb + 1]), 64'h2);
            chk("t2_wr2", 64'(wlog[wb + 2]), 64'h1);
            chk("t2_wr3", 64'(wlog[wb + 3]), 64'h2);
            chk("t2_rd0", 64'(rlog[rb]),     64'd0);
            chk("t2_rd1", 64'(rlog[rb + 1]), 64'd1);
            chk("t2_rd2", 64'(rlog[rb + 2]), 64'd0);
            chk("t2_rd3", 64'(rlog[rb + 3]), 64'd1);
        end

        // output buffer full for three polls
        out_full = 1'b1;
        reset    = 1'b1;
        repeat (2) tick;
        req0_data  = 64'h11;
        req1_data  = 64'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset      = 1'b0;
        tb0 = txp;
        xb  = rxp;
        wb  = wlog.size();
        rb  = rlog.size();
        for (int i = 0; i < 200; i++) begin
            tick;
            if (txp >= tb0 + 3) break;
        end
        chk("t3_polls", 64'(txp - tb0), 64'd3);
        chk("t3_nowr",  64'(wlog.size() - wb), 64'd0);
        chk("t3_nordy", 64'(rlog.size() - rb), 64'd0);
        out_full = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (wlog.size() > wb) break;
        end
        chk("t3_nwr",  64'(wlog.size() - wb), 64'd1);
        chk("t3_txp",  64'(txp - tb0), 64'd4);
        chk("t3_rxp",  64'(rxp - xb), 64'd3);
        if (wlog.size() > wb && rlog.size() > rb) begin
            chk("t3_wr0", 64'(wlog[wb]), 64'h11);
            chk("t3_rd0", 64'(rlog[rb]), 64'd0);
        end
        for (int i = 0; i < 200; i++) begin
            tick;
            if (wlog.size() >= wb + 2) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t3_nwr2", 64'(wlog.size() - wb), 64'd2);
        if (wlog.size() >= wb + 2) begin
            chk("t3_wr1", 64'(wlog[wb + 1]), 64'h22);
        end

        // receive path with consumer stalled
        reset = 1'b1;
        repeat (2) tick;
        in_full  = 1'b1;
        in_buf   = 64'hDEAD_BEEF;
        rx_ready = 1'b0;
        reset    = 1'b0;
        xb = rxp;
        tick;
        chk("t4_poll_en",   64'(nic_en), 64'd1);
        chk("t4_poll_addr", 64'(nic_addr), 64'd1);
        tick;
        tick;
        chk("t4_rd_en",   64'(nic_en), 64'd1);
        chk("t4_rd_addr", 64'(nic_addr), 64'd0);
        chk("t4_rd_wren", 64'(nic_wren), 64'd0);
        tick;
        chk("t4_rxv_early", 64'(rx_valid), 64'd0);
        tick;
        chk("t4_rxv", 64'(rx_valid), 64'd1);
        chk("t4_rxd", 64'(rx_data), 64'hDEAD_BEEF);
        in_buf = 64'h0123_4567_89AB_CDEF;
        repeat (20) tick;
        chk("t4_hold_v", 64'(rx_valid), 64'd1);
        chk("t4_hold_d", 64'(rx_data), 64'hDEAD_BEEF);
        chk("t4_nopoll", 64'(rxp - xb), 64'd1);
        rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
        chk("t4_clr_v", 64'(rx_valid), 64'd0);
        chk("t4_clr_d", 64'(rx_data), 64'hDEAD_BEEF);
        for (int i = 0; i < 50; i++) begin
            tick;
            if (rx_valid) break;
        end
        chk("t4_rxv2", 64'(rx_valid), 64'd1);
        chk("t4_rxd2", 64'(rx_data), 64'h0123_4567_89AB_CDEF);
        chk("t4_rxp2", 64'(rxp - xb), 64'd2);

        // reset clears rx state, then aborts a granted req1 in TX_WAIT
        in_full = 1'b0;
        reset   = 1'b1;
        tick;
        chk("t5_rst_rxv", 64'(rx_valid), 64'd0);
        chk("t5_rst_rxd", 64'(rx_data), 64'd0);
        tick;
        req1_data  = 64'h77;
        req1_valid = 1'b1;
        reset      = 1'b0;
        rb = rlog.size();
        wb = wlog.size();
        tick;
        chk("t5_poll_addr", 64'(nic_addr), 64'd3);
        tick;
        chk("t5_wait_en", 64'(nic_en), 64'd0);
        reset = 1'b1;
        tick;
        chk("t5_abort_en",   64'(nic_en), 64'd0);
        chk("t5_abort_rdy1", 64'(req1_ready), 64'd0);
        chk("t5_abort_log",  64'(rlog.size() - rb), 64'd0);
        reset = 1'b0;
        tick;
        chk("t5_repoll_en",   64'(nic_en), 64'd1);
        chk("t5_repoll_addr", 64'(nic_addr), 64'd3);
        tick;
        tick;
        chk("t5_rdy1", 64'(req1_ready), 64'd1);
        chk("t5_di",   64'(nic_di), 64'h77);
        chk("t5_wren", 64'(nic_wren), 64'd1);
        req1_valid = 1'b0;
        tick;
        chk("t5_nrdy", 64'(rlog.size() - rb), 64'd1);
        chk("t5_nwr",  64'(wlog.size() - wb), 64'd1);

        chk("no_blind_write", 64'(badwr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cardinal_nic_arbiter.md
CARDINAL_NIC_ARBITER -- requirements
Module: cardinal_nic_arbiter

Interface
REQ-001: The block SHALL have parameter DATA_WIDTH, default 64, giving packet/register width.
REQ-002: The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- nic_addr  out  [0:1]  NIC register select, to gold_nic addr
- nic_di  out  [0:DATA_WIDTH-1]  write data, to gold_nic d_in
- nic_en  out  1  NIC access enable, to gold_nic nicEn
- nic_wren  out  1  NIC write enable, to gold_nic nicEnWr
- nic_do  in  [0:DATA_WIDTH-1]  NIC read data, from gold_nic d_out, valid the cycle after a read access
- req0_valid / req1_valid  in  1  requester N has a packet to send
- req0_data / req1_data  in  [0:DATA_WIDTH-1]  requester N packet
- req0_ready / req1_ready  out  1  one-cycle pulse: requester N packet written to NIC
- rx_valid  out  1  received packet held in rx_data
- rx_data  out  [0:DATA_WIDTH-1]  received packet
- rx_ready  in  1  consumer accepts rx_data

Function
REQ-003: NIC register map SHALL be: 00 input buffer (read), 01 input status (read), 10 output buffer (write), 11 output status (read); status flag is bit DATA_WIDTH-1 (1 = full).
REQ-004: FSM states SHALL be IDLE, TX_POLL, TX_WAIT, TX_WRITE, RX_POLL, RX_WAIT, RX_READ, RX_RDWAIT.
REQ-005: NIC outputs SHALL be a Moore decode of state: TX_POLL en=1 wren=0 addr=11; TX_WRITE en=1 wren=1 addr=10 di=granted data; RX_POLL en=1 wren=0 addr=01; RX_READ en=1 wren=0 addr=00; all other states en=0 wren=0 addr=00 di=0.
REQ-006: In IDLE, tx_elig = req0_valid|req1_valid and rx_elig = ~rx_valid; neither -> stay IDLE; one -> start that sequence; both -> TX if turn=0, else RX.
REQ-007: Starting TX SHALL set turn=1; starting RX SHALL set turn=0.
REQ-008: On TX start the grant SHALL be latched: only one valid -> that requester; both -> requester rr_ptr.
REQ-009: TX_POLL -> TX_WAIT unconditionally; TX_WAIT samples nic_do: status bit 0 -> TX_WRITE, 1 -> IDLE with no ready pulse and rr_ptr unchanged.
REQ-010: In TX_WRITE the granted reqN_ready SHALL be 1 for exactly that cycle, rr_ptr SHALL become the non-granted index, next state IDLE.
REQ-011: Requesters SHALL hold valid and data stable until ready; the arbiter SHALL NOT check for early deassertion.
REQ-012: RX_POLL -> RX_WAIT unconditionally; RX_WAIT: status bit 1 -> RX_READ, 0 -> IDLE.
REQ-013: RX_READ -> RX_RDWAIT unconditionally; in RX_RDWAIT rx_data SHALL capture nic_do, rx_valid SHALL be set, next state IDLE.
REQ-014: rx_valid SHALL clear on a cycle with rx_valid & rx_ready; rx_data SHALL hold its value until the next capture.
REQ-015: Best-case latency SHALL be: reqN_ready 3 cycles after IDLE sees valid; rx_valid high 5 cycles after IDLE starts RX_POLL decision.
REQ-016: No NIC write SHALL occur unless the immediately preceding output-status read in the same sequence returned not-full.
REQ-017: With both requesters continuously valid and the NIC never full, grants SHALL alternate 0,1,0,1,...; no requester SHALL wait more than two TX sequences.

Reset
REQ-018: reset SHALL force state=IDLE, rr_ptr=0, turn=0, rx_valid=0, rx_data=0; all outputs 0 in the same cycle via Moore decode.
REQ-019: reset asserted mid-sequence SHALL abort it with no ready pulse and no rx capture; a packet granted but not written SHALL be re-arbitrated after reset.

Verification
REQ-020: Reset, req0_valid=1 data=64'hA5, status reads 0 -> TX_POLL addr=11, TX_WRITE addr=10 di=64'hA5 wren=1, req0_ready pulse 3 cycles after valid.
REQ-021: Both requesters valid (64'h1, 64'h2), status never full -> writes in order 64'h1, 64'h2, 64'h1 ..., ready pulses alternate.
REQ-022: Output status full for 3 polls then empty -> 3 TX_POLL/TX_WAIT aborts with no write, RX polls interleaved by turn, 4th poll writes, rr_ptr unchanged until then.
REQ-023: Input status full, nic_do at RX_RDWAIT = 64'hDEAD_BEEF, rx_ready=0 -> rx_valid=1 rx_data=64'hDEAD_BEEF held; no further RX_POLL until rx_ready=1 for one cycle.
REQ-024: reset asserted during TX_WAIT with req1 granted -> next cycle IDLE, outputs 0, no req1_ready; after release req1 completes normally.
